free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL use the shared constants PHYS_REGS, ARCH_REGS, PHYS_WIDTH and PROCESSOR_WIDTH, plus the new constant FL_DEPTH = PHYS_REGS - ARCH_REGS.
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high; the ports are named clk and rst as elsewhere in the core.
REQ-003 clk  in  1  core clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 alloc_en[PROCESSOR_WIDTH]  in  1  rename lane w consumes free_paddr[w] this cycle.
REQ-006 stall_dispatch  in  1  suppresses all allocation this cycle.
REQ-007 free_paddr[PROCESSOR_WIDTH]  out  PHYS_WIDTH  offered register per lane; feeds rename_paddr.
REQ-008 free_valid[PROCESSOR_WIDTH]  out  1  free_paddr[w] is usable.
REQ-009 commit_en[PROCESSOR_WIDTH]  in  1  retiring instruction with a renamed rd.
REQ-010 commit_old_paddr[PROCESSOR_WIDTH]  in  PHYS_WIDTH  prior mapping of that rd, being freed.
REQ-011 br_flush  in  1  squash all speculative allocations.
REQ-012 free_count  out  $clog2(FL_DEPTH+1)  current number of entries available to rename.

Function
REQ-013 Storage: circular array of FL_DEPTH PHYS_WIDTH-bit entries; head (speculative read), arch_head (committed read), tail (write); each pointer is $clog2(FL_DEPTH) bits plus a wrap bit.
REQ-014 Lane w offers entry head+w (mod FL_DEPTH); free_valid[w] = (free_count > w); outputs are combinational from registered state.
REQ-015 Effective allocation on lane w = alloc_en[w] & !stall_dispatch & !br_flush; head advances by the popcount of effective allocations.
REQ-016 Lanes allocate in order: alloc_en[w] high while alloc_en[w-1] is low is illegal and SHALL be flagged by an assertion; allocation with free_valid[w] low is likewise illegal.
REQ-017 Each commit_en[w] writes commit_old_paddr[w] at tail+(index among active commits), advances tail, and advances arch_head by the same count.
REQ-018 A freed register SHALL become allocatable no earlier than the next cycle; there is no same-cycle bypass.
REQ-019 On br_flush, commits in that cycle are applied first, then head <= the updated arch_head; free_count becomes tail - arch_head; allocations that cycle are ignored.
REQ-020 Simultaneous allocate and commit SHALL both take effect; free_count_next = free_count - allocs + commits.
REQ-021 When empty, all free_valid are 0 and head is frozen; the array can never overflow because the number of commits is bounded by prior allocations (assertion: free_count <= FL_DEPTH).
REQ-022 Pointer arithmetic SHALL wrap modulo FL_DEPTH with the wrap bit toggled; full/empty are distinguished by the wrap bit.

Reset
REQ-023 On rst, entry i SHALL be ARCH_REGS+i for i in 0..FL_DEPTH-1, matching the identity RAT/RRF mapping of physical registers 0..ARCH_REGS-1.
REQ-024 On rst: head = arch_head = 0 with wrap 0, tail = 0 with wrap 1, free_count = FL_DEPTH, and free_valid[w] = 1 for all w < min(PROCESSOR_WIDTH, FL_DEPTH).
REQ-025 rst asserted mid-operation SHALL discard all state immediately and regardless of other inputs.

Structure
REQ-026 FL_DEPTH SHALL be added to rv32i_types next to PHYS_REGS and ARCH_REGS; no new typedefs are required.
REQ-027 The block SHALL be a single module with no sub-module; the pointer-increment and popcount helpers are local functions.

Verification (PHYS_REGS=64, ARCH_REGS=32, PROCESSOR_WIDTH=2)
REQ-028 Reset -> free_paddr = {32,33}, free_valid = {1,1}, free_count = 32.
REQ-029 Allocate 2 per cycle for 16 cycles -> registers 32..63 issued in order, then free_valid = {0,0} and free_count = 0.
REQ-030 From empty, commit old_paddr 5 -> free_valid[0] = 0 in the same cycle; next cycle free_paddr[0] = 5, free_valid = {1,0}.
REQ-031 Allocate 6, commit 2 (freeing 7 and 9), then br_flush -> head = arch_head, free_count = 32-2+2 = 32, free_paddr[0] = 34.
REQ-032 alloc_en = {1,1} with stall_dispatch = 1 -> head unchanged; alloc 1 and commit 1 in the same cycle -> free_count unchanged.
REQ-033 Run 100 or more cycles of random alloc/commit/flush including pointer wrap -> no register is ever duplicated across the free list and a RAT scoreboard model, and free_count matches the model.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core constants for the rename stage.
package rv32i_types;

    localparam int unsigned PHYS_REGS       = 64;
    localparam int unsigned ARCH_REGS       = 32;
    localparam int unsigned PHYS_WIDTH      = $clog2(PHYS_REGS);
    localparam int unsigned PROCESSOR_WIDTH = 2;
    localparam int unsigned FL_DEPTH        = PHYS_REGS - ARCH_REGS;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular buffer with a speculative head,
// a committed head that restores the speculative head on branch flush, and a tail.
module free_list
    import rv32i_types::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PROCESSOR_WIDTH-1:0]        alloc_en,
    input  logic                              stall_dispatch,
    output logic [PHYS_WIDTH-1:0]             free_paddr [PROCESSOR_WIDTH],
    output logic [PROCESSOR_WIDTH-1:0]        free_valid,
    input  logic [PROCESSOR_WIDTH-1:0]        commit_en,
    input  logic [PHYS_WIDTH-1:0]             commit_old_paddr [PROCESSOR_WIDTH],
    input  logic                              br_flush,
    output logic [$clog2(FL_DEPTH+1)-1:0]     free_count
);

    localparam int unsigned IDX_W  = $clog2(FL_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FL_DEPTH + 1);
    localparam int unsigned LANE_W = $clog2(PROCESSOR_WIDTH + 1);

    logic [PHYS_WIDTH-1:0]      mem_q [FL_DEPTH];
    logic [IDX_W:0]             head_q, head_d;
    logic [IDX_W:0]             arch_head_q, arch_head_d;
    logic [IDX_W:0]             tail_q, tail_d;
    logic [PROCESSOR_WIDTH-1:0] alloc_eff;
    logic [LANE_W-1:0]          n_alloc, n_commit;
    logic [IDX_W-1:0]           wr_idx [PROCESSOR_WIDTH];

    function automatic logic [IDX_W:0] idx_sum(input logic [IDX_W-1:0] idx,
                                               input logic [LANE_W-1:0] n);
        return {1'b0, idx} + (IDX_W+1)'(n);
    endfunction

    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] idx,
                                                 input logic [LANE_W-1:0] n);
        logic [IDX_W:0] s;
        s = idx_sum(idx, n);
        if (s >= (IDX_W+1)'(FL_DEPTH)) s = s - (IDX_W+1)'(FL_DEPTH);
        return s[IDX_W-1:0];
    endfunction

    // Advance a wrap-tagged pointer; the wrap bit flips when the index rolls over.
    function automatic logic [IDX_W:0] ptr_add(input logic [IDX_W:0]    p,
                                               input logic [LANE_W-1:0] n);
        logic wrap_flip;
        wrap_flip = idx_sum(p[IDX_W-1:0], n) >= (IDX_W+1)'(FL_DEPTH);
        return {p[IDX_W] ^ wrap_flip, idx_add(p[IDX_W-1:0], n)};
    endfunction

    function automatic logic [LANE_W-1:0] popcount(input logic [PROCESSOR_WIDTH-1:0] v);
        logic [LANE_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(PROCESSOR_WIDTH); i++) c = c + LANE_W'(v[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] ptr_dist(input logic [IDX_W:0] t,
                                                  input logic [IDX_W:0] h);
        if (t[IDX_W] == h[IDX_W])
            return CNT_W'(t[IDX_W-1:0]) - CNT_W'(h[IDX_W-1:0]);
        else
            return CNT_W'(FL_DEPTH) - CNT_W'(h[IDX_W-1:0]) + CNT_W'(t[IDX_W-1:0]);
    endfunction

    // Offered registers come straight from registered state; freed entries show up next cycle.
    always_comb begin
        free_count = ptr_dist(tail_q, head_q);
        for (int w = 0; w < int'(PROCESSOR_WIDTH); w++) begin
            free_valid[w] = free_count > CNT_W'(w);
            free_paddr[w] = mem_q[idx_add(head_q[IDX_W-1:0], LANE_W'(w))];
        end
    end

    always_comb begin
        n_commit = '0;
        for (int w = 0; w < int'(PROCESSOR_WIDTH); w++) begin
            alloc_eff[w] = alloc_en[w] & ~stall_dispatch & ~br_flush;
            wr_idx[w]    = idx_add(tail_q[IDX_W-1:0], n_commit);
            n_commit     = n_commit + LANE_W'(commit_en[w]);
        end
        n_alloc     = popcount(alloc_eff);
        tail_d      = ptr_add(tail_q, n_commit);
        arch_head_d = ptr_add(arch_head_q, n_commit);
        head_d      = br_flush ? arch_head_d : ptr_add(head_q, n_alloc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= {1'b1, IDX_W'(0)};
            for (int i = 0; i < int'(FL_DEPTH); i++)
                mem_q[i] <= PHYS_WIDTH'(ARCH_REGS + 32'(i));
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            for (int w = 0; w < int'(PROCESSOR_WIDTH); w++)
                if (commit_en[w]) mem_q[wr_idx[w]] <= commit_old_paddr[w];
        end
    end

    for (genvar w = 1; w < int'(PROCESSOR_WIDTH); w++) begin : g_lane_order
        a_in_order: assert property (@(posedge clk) disable iff (rst)
            !(alloc_en[w] && !alloc_en[w-1]))
            else $error("free_list: lane %0d allocates while lane %0d does not", w, w-1);
    end

    for (genvar w = 0; w < int'(PROCESSOR_WIDTH); w++) begin : g_lane_valid
        a_alloc_valid: assert property (@(posedge clk) disable iff (rst)
            alloc_eff[w] |-> free_valid[w])
            else $error("free_list: lane %0d allocates an invalid entry", w);
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        free_count <= CNT_W'(FL_DEPTH))
        else $error("free_list: free_count exceeds depth");

endmodule

// File: tb/tb_free_list.sv
// Randomised bench for free_list against a queue-based free list and RAT/ROB model.
module tb_free_list;
    import rv32i_types::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [PROCESSOR_WIDTH-1:0]    alloc_en;
    logic                          stall_dispatch;
    logic [PHYS_WIDTH-1:0]         free_paddr [PROCESSOR_WIDTH];
    logic [PROCESSOR_WIDTH-1:0]    free_valid;
    logic [PROCESSOR_WIDTH-1:0]    commit_en;
    logic [PHYS_WIDTH-1:0]         commit_old_paddr [PROCESSOR_WIDTH];
    logic                          br_flush;
    logic [$clog2(FL_DEPTH+1)-1:0] free_count;

    free_list dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_en         (alloc_en),
        .stall_dispatch   (stall_dispatch),
        .free_paddr       (free_paddr),
        .free_valid       (free_valid),
        .commit_en        (commit_en),
        .commit_old_paddr (commit_old_paddr),
        .br_flush         (br_flush),
        .free_count       (free_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // fq holds every entry from the committed head to the tail; spec is how many are speculatively taken.
    int fq[$];
    int spec;

    typedef struct { int rd; int newp; int oldp; } rob_t;
    rob_t rob[$];
    int rat [ARCH_REGS];
    int rrf [ARCH_REGS];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < int'(FL_DEPTH); i++) fq.push_back(int'(ARCH_REGS) + i);
        spec = 0;
        for (int r = 0; r < int'(ARCH_REGS); r++) begin
            rat[r] = r;
            rrf[r] = r;
        end
        rob.delete();
    endtask

    function automatic int model_count();
        return fq.size() - spec;
    endfunction

    task automatic model_step(input logic [1:0] a, input logic s, input logic [1:0] c,
                              input int p0, input int p1, input logic f);
        int na, nc;
        na = (f || s) ? 0 : int'(a[0]) + int'(a[1]);
        nc = int'(c[0]) + int'(c[1]);
        for (int k = 0; k < nc; k++) void'(fq.pop_front());
        spec -= nc;
        if (c[0]) fq.push_back(p0);
        if (c[1]) fq.push_back(p1);
        if (f) spec = 0;
        else   spec += na;
    endtask

    task automatic drive(input logic [1:0] a, input logic s, input logic [1:0] c,
                         input int p0, input int p1, input logic f);
        alloc_en            = a;
        stall_dispatch      = s;
        commit_en           = c;
        commit_old_paddr[0] = PHYS_WIDTH'(p0);
        commit_old_paddr[1] = PHYS_WIDTH'(p1);
        br_flush            = f;
    endtask

    task automatic cycle(input logic [1:0] a, input logic s, input logic [1:0] c,
                         input int p0, input int p1, input logic f);
        drive(a, s, c, p0, p1, f);
        model_step(a, s, c, p0, p1, f);
        @(negedge clk);
    endtask

    task automatic check_model(input bit with_rat);
        int  cnt;
        bit  held [PHYS_REGS];
        int  expv;
        cnt  = model_count();
        expv = (cnt > 0 ? 1 : 0) + (cnt > 1 ? 2 : 0);
        check_eq("count", int'(free_count), cnt);
        check_eq("valid", int'(free_valid), expv);
        for (int p = 0; p < int'(PHYS_REGS); p++) held[p] = 1'b0;
        for (int r = 0; r < int'(ARCH_REGS); r++) held[rat[r]] = 1'b1;
        foreach (rob[i]) begin
            held[rob[i].newp] = 1'b1;
            held[rob[i].oldp] = 1'b1;
        end
        for (int w = 0; w < 2; w++) begin
            if (cnt > w) begin
                check_eq($sformatf("paddr%0d", w), int'(free_paddr[w]), fq[spec+w]);
                if (with_rat)
                    check_eq($sformatf("dup%0d", w), int'(held[free_paddr[w]]), 0);
            end
        end
    endtask

    task automatic do_reset();
        drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        check_eq("rst_count", int'(free_count), 32);
        check_eq("rst_valid", int'(free_valid), 3);
        check_eq("rst_p0", int'(free_paddr[0]), 32);
        check_eq("rst_p1", int'(free_paddr[1]), 33);

        // Stall holds head; alloc+commit together leaves the count unchanged.
        cycle(2'b11, 1'b1, 2'b00, 0, 0, 1'b0);
        check_eq("stall_p0", int'(free_paddr[0]), 32);
        check_eq("stall_count", int'(free_count), 32);
        cycle(2'b11, 1'b0, 2'b00, 0, 0, 1'b0);
        check_eq("alloc2_count", int'(free_count), 30);
        cycle(2'b01, 1'b0, 2'b01, 32, 0, 1'b0);
        check_eq("ac_count", int'(free_count), 30);
        check_eq("ac_p0", int'(free_paddr[0]), 35);
        check_model(1'b0);

        // Drain the whole list in order.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_p0", int'(free_paddr[0]), 32 + 2*i);
            check_eq("drain_p1", int'(free_paddr[1]), 33 + 2*i);
            cycle(2'b11, 1'b0, 2'b00, 0, 0, 1'b0);
        end
        check_eq("empty_valid", int'(free_valid), 0);
        check_eq("empty_count", int'(free_count), 0);

        // A freed register is not offered until the following cycle.
        drive(2'b00, 1'b0, 2'b01, 5, 0, 1'b0);
        model_step(2'b00, 1'b0, 2'b01, 5, 0, 1'b0);
        #1;
        check_eq("nobypass_valid", int'(free_valid), 0);
        @(negedge clk);
        check_eq("freed_p0", int'(free_paddr[0]), 5);
        check_eq("freed_valid", int'(free_valid), 1);
        check_eq("freed_count", int'(free_count), 1);

        // Flush after partial commit restores head to the committed head.
        do_reset();
        repeat (3) cycle(2'b11, 1'b0, 2'b00, 0, 0, 1'b0);
        cycle(2'b00, 1'b0, 2'b11, 7, 9, 1'b0);
        check_eq("pre_flush_count", int'(free_count), 28);
        cycle(2'b11, 1'b0, 2'b00, 0, 0, 1'b1);
        check_eq("flush_count", int'(free_count), 32);
        check_eq("flush_p0", int'(free_paddr[0]), 34);
        check_eq("flush_p1", int'(free_paddr[1]), 35);
        check_model(1'b0);

        // Random rename/commit/flush traffic with a RAT/ROB scoreboard.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int         cnt, na, nc, rd;
            int         p [2];
            logic [1:0] a, c;
            logic       s, f;
            rob_t       e;
            cnt = model_count();
            f   = ($urandom_range(15) == 0);
            s   = ($urandom_range(7) == 0);
            na  = $urandom_range(2);
            if (na > cnt) na = cnt;
            a   = (na == 0) ? 2'b00 : (na == 1) ? 2'b01 : 2'b11;
            nc  = $urandom_range(2);
            if (nc > rob.size()) nc = rob.size();
            c   = (nc == 2) ? 2'b11 : (nc == 1) ? ($urandom_range(1) ? 2'b10 : 2'b01) : 2'b00;
            p[0] = 0;
            p[1] = 0;
            for (int w = 0; w < 2; w++) begin
                if (c[w]) begin
                    e = rob.pop_front();
                    rrf[e.rd] = e.newp;
                    p[w] = e.oldp;
                end
            end
            if (f) begin
                for (int r = 0; r < int'(ARCH_REGS); r++) rat[r] = rrf[r];
                rob.delete();
            end else if (!s) begin
                for (int w = 0; w < na; w++) begin
                    rd     = $urandom_range(int'(ARCH_REGS) - 1);
                    e.rd   = rd;
                    e.newp = fq[spec+w];
                    e.oldp = rat[rd];
                    rat[rd] = e.newp;
                    rob.push_back(e);
                end
            end
            cycle(a, s, c, p[0], p[1], f);
            check_model(1'b1);
        end

        // Reset mid-operation takes effect without waiting for a clock edge.
        drive(model_count() >= 2 ? 2'b11 : 2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_count", int'(free_count), 32);
        check_eq("arst_p0", int'(free_paddr[0]), 32);
        check_eq("arst_p1", int'(free_paddr[1]), 33);
        @(negedge clk);
        drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_model(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
